// File: rtl/mac_window_loader_if.sv
// Operand and result streams of mac_window_loader.
//
// Handshake: on both channels a transfer happens on a rising clk edge where
// valid && ready are both high. Once the source raises valid, it holds the
// payload stable until that edge. Ready may depend on state only. It never
// depends on the same channel's valid.
interface mac_window_loader_if #(
  parameter int PIXEL_WIDTH  = 10,
  parameter int WEIGHT_WIDTH = 19,
  parameter int OUTPUT_WIDTH = 26
);
  logic                    in_valid;
  logic                    in_ready;
  logic [PIXEL_WIDTH-1:0]  in_pixel;
  logic [WEIGHT_WIDTH-1:0] in_weight;
  logic                    res_valid;
  logic                    res_ready;
  logic [OUTPUT_WIDTH-1:0] res_data;
  logic                    res_err;

  // Producer of operand pairs and consumer of results.
  modport master (
    output in_valid, in_pixel, in_weight, res_ready,
    input  in_ready, res_valid, res_data, res_err
  );

  // The loader itself.
  modport slave (
    input  in_valid, in_pixel, in_weight, res_ready,
    output in_ready, res_valid, res_data, res_err
  );
endinterface

// File: rtl/mac_window_loader.sv
// mac_window_loader: packs serial (pixel, weight) pairs into the MAC lane
// buses, releases the MAC from reset, and captures its result into a one-deep
// result slot. A pending register holds the result while the slot is busy, so
// the MAC is never left running after completion.
// Optional feature: define MAC_TIMEOUT_EN to add a RUN watchdog. The watchdog
// flags its forced captures on res_err.
module mac_window_loader #(
  parameter int NUM_INPUTS   = 4,
  parameter int PIXEL_WIDTH  = 10,
  parameter int WEIGHT_WIDTH = 19,
  parameter int OUTPUT_WIDTH = 26
`ifdef MAC_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 32
`endif
) (
  input  logic                               clk,
  input  logic                               rst,
  mac_window_loader_if.slave                 bus,
  output logic [NUM_INPUTS*PIXEL_WIDTH-1:0]  mac_pixels,
  output logic [NUM_INPUTS*WEIGHT_WIDTH-1:0] mac_weights,
  output logic                               mac_rst,
  input  logic [OUTPUT_WIDTH-1:0]            mac_out,
  input  logic                               mac_done,
  output logic [1:0]                         dbg_state
);

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_RUN  = 2'd1,
    S_PEND = 2'd2
  } state_t;

  localparam int CNT_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(NUM_INPUTS - 1);

  state_t                  state;
  state_t                  state_next;
  logic [CNT_W-1:0]        cnt;
  logic                    run_first;
  logic [OUTPUT_WIDTH-1:0] pend_data;
  logic [OUTPUT_WIDTH-1:0] res_data_q;
  logic                    res_valid_q;
  logic                    accept;
  logic                    slot_free;
  logic                    capture;
  logic                    load_slot;
  logic                    park;
  logic [OUTPUT_WIDTH-1:0] load_data;

`ifdef MAC_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt;
  logic            timeout;
  logic            load_err;
  logic            pend_err;
  logic            res_err_q;
`endif

  assign accept    = bus.in_valid && (state == S_FILL);
  assign slot_free = !res_valid_q || bus.res_ready;

  // The MAC step counter is 0 on the first RUN cycle, so a done seen there
  // is stale and gets ignored.
`ifdef MAC_TIMEOUT_EN
  assign timeout = !mac_done && (wd_cnt == WD_LAST);
  assign capture = (state == S_RUN) && !run_first && (mac_done || timeout);
`else
  assign capture = (state == S_RUN) && !run_first && mac_done;
`endif

  // Next state, and which value (if any) loads into the result slot or pend.
  always_comb begin
    state_next = state;
    load_slot  = 1'b0;
    load_data  = mac_out;
    park       = 1'b0;
`ifdef MAC_TIMEOUT_EN
    load_err   = 1'b0;
`endif
    case (state)
      S_FILL: begin
        if (accept && (cnt == LAST_LANE)) state_next = S_RUN;
      end
      S_RUN: begin
        if (capture) begin
          if (slot_free) begin
            load_slot  = 1'b1;
            load_data  = mac_out;
`ifdef MAC_TIMEOUT_EN
            load_err   = timeout;
`endif
            state_next = S_FILL;
          end else begin
            park       = 1'b1;
            state_next = S_PEND;
          end
        end
      end
      S_PEND: begin
        if (slot_free) begin
          load_slot  = 1'b1;
          load_data  = pend_data;
`ifdef MAC_TIMEOUT_EN
          load_err   = pend_err;
`endif
          state_next = S_FILL;
        end
      end
      default: state_next = S_FILL;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FILL;
    else     state <= state_next;
  end

  // Lane fill: each accepted pair goes into lane cnt. Lanes keep their value until overwritten.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      mac_pixels  <= '0;
      mac_weights <= '0;
    end else if (accept) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (cnt == CNT_W'(i)) begin
          mac_pixels[i*PIXEL_WIDTH +: PIXEL_WIDTH]    <= bus.in_pixel;
          mac_weights[i*WEIGHT_WIDTH +: WEIGHT_WIDTH] <= bus.in_weight;
        end
      end
      cnt <= (cnt == LAST_LANE) ? '0 : cnt + CNT_W'(1);
    end
  end

  // MAC control: registered reset (low only in RUN), first-RUN-cycle flag, pending capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mac_rst   <= 1'b1;
      run_first <= 1'b0;
      pend_data <= '0;
    end else begin
      mac_rst   <= (state_next != S_RUN);
      run_first <= (state != S_RUN) && (state_next == S_RUN);
      if (park) pend_data <= mac_out;
    end
  end

  // Result slot: a new load wins over the consumer handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else if (load_slot) begin
      res_valid_q <= 1'b1;
      res_data_q  <= load_data;
    end else if (res_valid_q && bus.res_ready) begin
      res_valid_q <= 1'b0;
    end
  end

`ifdef MAC_TIMEOUT_EN
  // Watchdog: counts RUN cycles from 0 at RUN entry. Error flag follows the data through pend and slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt    <= '0;
      pend_err  <= 1'b0;
      res_err_q <= 1'b0;
    end else begin
      if ((state != S_RUN) && (state_next == S_RUN)) wd_cnt <= '0;
      else if (state == S_RUN)                       wd_cnt <= wd_cnt + WD_W'(1);
      if (park)      pend_err  <= timeout;
      if (load_slot) res_err_q <= load_err;
    end
  end

  assign bus.res_err = res_err_q;
`else
  assign bus.res_err = 1'b0;
`endif

  assign bus.in_ready  = (state == S_FILL);
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_mac_window_loader.sv
// Directed bench for mac_window_loader, with a behavioural MAC that raises
// done 10 steps after its reset drops and outputs the lane dot product.
module tb_mac_window_loader;
  localparam int N  = 4;
  localparam int PW = 10;
  localparam int WW = 19;
  localparam int OW = 26;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int unsigned edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "global timeout");
  end

  // ---------------- DUT ----------------
  mac_window_loader_if #(.PIXEL_WIDTH(PW), .WEIGHT_WIDTH(WW), .OUTPUT_WIDTH(OW)) bus ();

  logic [N*PW-1:0] mac_pixels;
  logic [N*WW-1:0] mac_weights;
  logic            mac_rst;
  logic [OW-1:0]   mac_out;
  logic            mac_done;
  logic [1:0]      dbg_state;

  mac_window_loader #(
    .NUM_INPUTS(N), .PIXEL_WIDTH(PW), .WEIGHT_WIDTH(WW), .OUTPUT_WIDTH(OW)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .mac_pixels(mac_pixels), .mac_weights(mac_weights), .mac_rst(mac_rst),
    .mac_out(mac_out), .mac_done(mac_done), .dbg_state(dbg_state)
  );

  // ---------------- MAC model ----------------
  logic        stub_mode = 1'b0;
  int unsigned mac_step  = 0;
  always @(posedge clk) begin
    if (mac_rst)            mac_step <= 0;
    else if (mac_step < 15) mac_step <= mac_step + 1;
  end

  function automatic logic [OW-1:0] mac_sum(input logic [N*PW-1:0] px, input logic [N*WW-1:0] wt);
    logic signed [31:0]   acc;
    logic signed [PW-1:0] p;
    logic signed [WW-1:0] w;
    acc = 0;
    for (int i = 0; i < N; i++) begin
      p   = px[i*PW +: PW];
      w   = wt[i*WW +: WW];
      acc = acc + p * w;
    end
    return acc[OW-1:0];
  endfunction

  assign mac_done = !stub_mode && (mac_step >= 10);
  assign mac_out  = stub_mode ? 26'h0000123 : mac_sum(mac_pixels, mac_weights);

  // ---------------- checking ----------------
  int checks   = 0;
  int failures = 0;
  int unsigned last_accept_edge = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_pair(input logic [PW-1:0] p, input logic [WW-1:0] w);
    int guard;
    guard = 0;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_pixel  = p;
    bus.in_weight = w;
    while (bus.in_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("send_in_ready", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;
    last_accept_edge = edge_cnt;
    bus.in_valid  = 1'b0;
    bus.in_pixel  = '1;
    bus.in_weight = '1;
  endtask

  task automatic send_window(input logic [PW-1:0] p0, input logic [PW-1:0] p1,
                             input logic [PW-1:0] p2, input logic [PW-1:0] p3,
                             input logic [WW-1:0] w, input logic throttle);
    logic [PW-1:0] px [4];
    px[0] = p0; px[1] = p1; px[2] = p2; px[3] = p3;
    for (int i = 0; i < 4; i++) begin
      if (throttle) @(negedge clk);
      send_pair(px[i], w);
    end
  endtask

  task automatic wait_result(input string tag, input int unsigned exp_lat,
                             input logic [OW-1:0] exp_data, input logic exp_err);
    int guard;
    guard = 0;
    while (bus.res_valid !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_valid"},   bus.res_valid, 1'b1);
    check({tag, "_latency"}, edge_cnt - last_accept_edge, exp_lat);
    check({tag, "_data"},    bus.res_data, exp_data);
    check({tag, "_err"},     bus.res_err, exp_err);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_pixel  = 10'h155;
    bus.in_weight = 19'h2AAAA;
    bus.res_ready = 1'b1;

    // Reset values; valid held high while in reset must not load anything.
    repeat (3) @(negedge clk);
    check("rst_in_ready",  bus.in_ready, 1'b1);
    check("rst_mac_rst",   mac_rst, 1'b1);
    check("rst_res_valid", bus.res_valid, 1'b0);
    check("rst_res_err",   bus.res_err, 1'b0);
    check("rst_res_data",  bus.res_data, 26'h0);
    check("rst_pixels",    mac_pixels, 40'h0);
    check("rst_weights",   mac_weights, 76'h0);
    check("rst_state",     dbg_state, 2'd0);
    bus.in_valid = 1'b0;
    rst          = 1'b0;

    // Positive window: 5.0 in sfix26_En18.
    send_window(10'd1, 10'd2, 10'd3, 10'd4, 19'h20000, 1'b0);
    @(negedge clk);
    check("pos_run_in_ready", bus.in_ready, 1'b0);
    check("pos_run_mac_rst",  mac_rst, 1'b0);
    check("pos_run_state",    dbg_state, 2'd1);
    wait_result("pos", 11, 26'h0140000, 1'b0);
    check("pos_in_ready_back", bus.in_ready, 1'b1);
    check("pos_pixels",  mac_pixels, {10'd4, 10'd3, 10'd2, 10'd1});
    check("pos_weights", mac_weights, {4{19'h20000}});

    // Negative window, started right after the previous result: -12.0.
    send_window(10'd3, 10'd3, 10'd3, 10'd3, 19'h40000, 1'b0);
    check("neg_first_accept_gap", last_accept_edge > 0, 1'b1);
    wait_result("neg", 11, 26'h3D00000, 1'b0);

    // Back-pressure across two windows.
    @(negedge clk);
    bus.res_ready = 1'b0;
    send_window(10'd1, 10'd2, 10'd3, 10'd4, 19'h20000, 1'b0);
    wait_result("bp_a", 11, 26'h0140000, 1'b0);
    send_window(10'd3, 10'd3, 10'd3, 10'd3, 19'h40000, 1'b0);
    repeat (14) @(negedge clk);
    check("bp_pend_state",     dbg_state, 2'd2);
    check("bp_pend_in_ready",  bus.in_ready, 1'b0);
    check("bp_pend_mac_rst",   mac_rst, 1'b1);
    check("bp_hold_valid",     bus.res_valid, 1'b1);
    check("bp_hold_data",      bus.res_data, 26'h0140000);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    check("bp_b_valid",    bus.res_valid, 1'b1);
    check("bp_b_data",     bus.res_data, 26'h3D00000);
    check("bp_b_err",      bus.res_err, 1'b0);
    check("bp_b_in_ready", bus.in_ready, 1'b1);
    check("bp_b_state",    dbg_state, 2'd0);
    bus.res_ready = 1'b1;
    @(negedge clk);
    check("bp_drained", bus.res_valid, 1'b0);

    // Reset mid-fill: the partial window must leave no residue.
    send_pair(10'd9, 19'h7FFFF);
    send_pair(10'd9, 19'h12345);
    #2 rst = 1'b1;
    #1;
    check("rfill_pixels",  mac_pixels, 40'h0);
    check("rfill_weights", mac_weights, 76'h0);
    check("rfill_state",   dbg_state, 2'd0);
    @(negedge clk);
    rst = 1'b0;
    send_window(10'd1, 10'd1, 10'd1, 10'd1, 19'h40000, 1'b0);
    wait_result("rfill", 11, 26'h3F00000, 1'b0);
    check("rfill_new_pixels", mac_pixels, {10'd1, 10'd1, 10'd1, 10'd1});

    // Throttled input: idle cycles carry junk that must not reach the lanes.
    @(negedge clk);
    send_pair(10'd1, 19'h20000);
    @(negedge clk);
    send_pair(10'd2, 19'h20000);
    @(negedge clk);
    check("thr_partial_pixels", mac_pixels, {10'd1, 10'd1, 10'd2, 10'd1});
    check("thr_partial_weights", mac_weights, {19'h40000, 19'h40000, 19'h20000, 19'h20000});
    send_pair(10'd3, 19'h20000);
    @(negedge clk);
    send_pair(10'd4, 19'h20000);
    wait_result("thr", 11, 26'h0140000, 1'b0);
    check("thr_pixels", mac_pixels, {10'd4, 10'd3, 10'd2, 10'd1});

    // Reset mid-RUN: MAC goes back to reset and no result appears.
    send_window(10'd5, 10'd6, 10'd7, 10'd8, 19'h20000, 1'b1);
    repeat (3) @(negedge clk);
    check("rrun_mac_rst_low", mac_rst, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("rrun_mac_rst",  mac_rst, 1'b1);
    check("rrun_state",    dbg_state, 2'd0);
    check("rrun_in_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    check("rrun_no_result", bus.res_valid, 1'b0);
    check("rrun_idle_state", dbg_state, 2'd0);

`ifdef MAC_TIMEOUT_EN
    // Watchdog with a MAC that never finishes.
    stub_mode = 1'b1;
    send_window(10'd1, 10'd2, 10'd3, 10'd4, 19'h20000, 1'b0);
    wait_result("wd", 32, 26'h0000123, 1'b1);
    stub_mode = 1'b0;
`endif

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
